// File: rtl/vdec_pkg.sv
// vdec_pkg: shared types for the vector decode stage.
//   ext_sel_e : immediate extension selector encodings
//   ctrl_t    : decoded control bundle carried from fetch into the ID/EX slot
package vdec_pkg;

    typedef enum logic [1:0] {
        EXT_NONE   = 2'b00,  // no immediate, rs1/rs2 come from the file
        EXT_SEXT19 = 2'b01,  // sign-extend imm[18:0]
        EXT_ZEXT27 = 2'b10,  // zero-extend imm[26:0]
        EXT_ZEXT_J = 2'b11   // zero-extend imm[26:0], no destination register
    } ext_sel_e;

    typedef struct packed {
        logic       vf;
        logic       wmem;
        logic       rmem;
        logic       wreg;
        logic       cond_en;
        logic [1:0] jmp;
        logic       jmp_sel;
        logic [1:0] rmux_sel;
        logic [2:0] alu_op;
        ext_sel_e   ext_sel;
    } ctrl_t;

endpackage

// File: rtl/vdec_regfile.sv
// vdec_regfile: register file, two async read ports, one write port.
//   clk, rst_n    : clock, async active-low reset (clears all entries)
//   we/waddr/wdata: write port, takes effect at the rising edge
//   ra0/rd0       : read port 0
//   ra1/rd1       : read port 1
// A read hitting the address being written returns wdata in the same cycle.
// With ZERO0=1 entry 0 reads as zero and ignores writes; that check wins
// over the bypass.
module vdec_regfile #(
    parameter  int unsigned W     = 32,
    parameter  int unsigned NREG  = 16,
    parameter  bit          ZERO0 = 1'b0,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] ra0,
    output logic [W-1:0]  rd0,
    input  logic [AW-1:0] ra1,
    output logic [W-1:0]  rd1
);

    logic [W-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && !(ZERO0 && waddr == '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd0 = (ZERO0 && ra0 == '0)   ? '0    :
                 (we && waddr == ra0)   ? wdata : mem[ra0];
    assign rd1 = (ZERO0 && ra1 == '0)   ? '0    :
                 (we && waddr == ra1)   ? wdata : mem[ra1];

endmodule

// File: rtl/vec_decode_stage.sv
// vec_decode_stage: decode stage of the vector alpha-compositing ASIP.
//   in_valid/in_ready   : fetch handshake; in_* carry ctrl, addresses, imm, pc
//   flush               : taken branch, kills the slot and the incoming instr
//   ex_rmem/ex_vf/ex_rd : instruction in execute (load-use hazard detection)
//   wb_en/wb_vf/wb_addr/wb_data : writeback into scalar or vector file
//   out_valid/out_ready : execute handshake
//   out_ctrl/out_a/out_b/out_rd/out_rs1/out_rs2 : registered ID/EX slot
module vec_decode_stage
    import vdec_pkg::*;
#(
    parameter  int unsigned LANES = 4,
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned NREG  = 16,
    parameter  int unsigned IMMW  = 27,
    localparam int unsigned AW    = $clog2(NREG),
    localparam int unsigned VW    = LANES * XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  ctrl_t           in_ctrl,
    input  logic [AW-1:0]   in_rd,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic [IMMW-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    input  logic            ex_rmem,
    input  logic            ex_vf,
    input  logic [AW-1:0]   ex_rd,
    input  logic            wb_en,
    input  logic            wb_vf,
    input  logic [AW-1:0]   wb_addr,
    input  logic [VW-1:0]   wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output ctrl_t           out_ctrl,
    output logic [VW-1:0]   out_a,
    output logic [VW-1:0]   out_b,
    output logic [AW-1:0]   out_rd,
    output logic [AW-1:0]   out_rs1,
    output logic [AW-1:0]   out_rs2
);

    logic [1:0]      ext_sel;
    logic [1:0]      rmux_sel;
    logic [XLEN-1:0] ext_imm;
    logic [AW-1:0]   rd_eff, rs1_eff, rs2_eff;
    logic [XLEN-1:0] r_rs1, r_rs2;
    logic [VW-1:0]   v_rs1, v_rs2;
    logic [VW-1:0]   op_a, op_b;
    logic            rs1_haz, rs2_haz, hazard, accept;

    assign ext_sel  = in_ctrl.ext_sel;
    assign rmux_sel = in_ctrl.rmux_sel;

    always_comb begin
        ext_imm = '0;
        case (ext_sel)
            EXT_SEXT19:             ext_imm = XLEN'($signed(in_imm[18:0]));
            EXT_ZEXT27, EXT_ZEXT_J: ext_imm = XLEN'(in_imm);
            default:                ext_imm = '0;
        endcase
    end

    assign rd_eff  = (ext_sel == EXT_ZEXT_J) ? '0 : in_rd;
    assign rs1_eff = ext_sel[1]              ? '0 : in_rs1;
    assign rs2_eff = (ext_sel != EXT_NONE)   ? '0 : in_rs2;

    vdec_regfile #(.W(XLEN), .NREG(NREG), .ZERO0(1'b1)) u_sfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wb_en & ~wb_vf),
        .waddr (wb_addr),
        .wdata (wb_data[XLEN-1:0]),
        .ra0   (rs1_eff),
        .rd0   (r_rs1),
        .ra1   (rs2_eff),
        .rd1   (r_rs2)
    );

    vdec_regfile #(.W(VW), .NREG(NREG), .ZERO0(1'b0)) u_vfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wb_en & wb_vf),
        .waddr (wb_addr),
        .wdata (wb_data),
        .ra0   (rs1_eff),
        .rd0   (v_rs1),
        .ra1   (rs2_eff),
        .rd1   (v_rs2)
    );

    assign op_a = rmux_sel[1] ? v_rs1 : VW'(in_ctrl.jmp_sel ? in_pc : r_rs1);
    assign op_b = rmux_sel[0] ? v_rs2 : VW'((ext_sel != EXT_NONE) ? ext_imm : r_rs2);

    // A source only hazards when actually read from the file the load targets;
    // scalar R0 is hardwired so it can never depend on a load.
    assign rs1_haz = ~in_ctrl.jmp_sel & ~ext_sel[1] & (rmux_sel[1] == ex_vf) &
                     (in_rs1 == ex_rd) & (rmux_sel[1] | (in_rs1 != '0));
    assign rs2_haz = (ext_sel == EXT_NONE) & (rmux_sel[0] == ex_vf) &
                     (in_rs2 == ex_rd) & (rmux_sel[0] | (in_rs2 != '0));
    assign hazard  = out_valid & ex_rmem & in_valid & (rs1_haz | rs2_haz);

    assign in_ready = ~hazard & ~flush & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_rd    <= '0;
            out_rs1   <= '0;
            out_rs2   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_ctrl  <= in_ctrl;
            out_a     <= op_a;
            out_b     <= op_b;
            out_rd    <= rd_eff;
            out_rs1   <= rs1_eff;
            out_rs2   <= rs2_eff;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vec_decode_stage.sv
module tb_vec_decode_stage;
    import vdec_pkg::*;

    localparam int LANES = 4;
    localparam int XLEN  = 32;
    localparam int NREG  = 16;
    localparam int IMMW  = 27;
    localparam int AW    = 4;
    localparam int VW    = 128;
    localparam int CW    = $bits(ctrl_t);

    logic            clk, rst_n;
    logic            in_valid, in_ready;
    ctrl_t           in_ctrl;
    logic [AW-1:0]   in_rd, in_rs1, in_rs2;
    logic [IMMW-1:0] in_imm;
    logic [XLEN-1:0] in_pc;
    logic            flush, ex_rmem, ex_vf;
    logic [AW-1:0]   ex_rd;
    logic            wb_en, wb_vf;
    logic [AW-1:0]   wb_addr;
    logic [VW-1:0]   wb_data;
    logic            out_valid, out_ready;
    ctrl_t           out_ctrl;
    logic [VW-1:0]   out_a, out_b;
    logic [AW-1:0]   out_rd, out_rs1, out_rs2;

    vec_decode_stage #(.LANES(LANES), .XLEN(XLEN), .NREG(NREG), .IMMW(IMMW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_pc(in_pc), .flush(flush),
        .ex_rmem(ex_rmem), .ex_vf(ex_vf), .ex_rd(ex_rd),
        .wb_en(wb_en), .wb_vf(wb_vf), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_a(out_a), .out_b(out_b),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: architectural register contents and ID/EX slot
    logic [XLEN-1:0] m_r [NREG];
    logic [VW-1:0]   m_v [NREG];
    logic            m_valid;
    ctrl_t           m_ctrl;
    logic [VW-1:0]   m_a, m_b;
    logic [AW-1:0]   m_rd, m_rs1, m_rs2;

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) begin
            m_r[i] = '0;
            m_v[i] = '0;
        end
        m_valid = 1'b0;
        m_ctrl  = '0;
        m_a = '0; m_b = '0;
        m_rd = '0; m_rs1 = '0; m_rs2 = '0;
    endtask

    function automatic logic [XLEN-1:0] read_s(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wb_en && !wb_vf && wb_addr == a) return wb_data[XLEN-1:0];
        return m_r[a];
    endfunction

    function automatic logic [VW-1:0] read_v(input logic [AW-1:0] a);
        if (wb_en && wb_vf && wb_addr == a) return wb_data;
        return m_v[a];
    endfunction

    // One cycle: check in_ready against the model, clock, then check the slot.
    task automatic step();
        int               es, sv;
        logic [XLEN-1:0]  ext;
        logic [AW-1:0]    e_rd, e_rs1, e_rs2;
        logic [VW-1:0]    na, nb;
        logic             use1, use2, h1, h2, hz, rdy;
        logic             w_en, w_vf;
        logic [AW-1:0]    w_addr;
        logic [VW-1:0]    w_data;
        #1;
        es = int'(in_ctrl.ext_sel);
        if (es == 1) begin
            sv = int'(in_imm % (1 << 19));
            if (sv >= (1 << 18)) sv = sv - (1 << 19);
            ext = XLEN'(sv);
        end else if (es >= 2) begin
            ext = XLEN'(in_imm);
        end else begin
            ext = '0;
        end
        e_rd  = (es == 3) ? 4'd0 : in_rd;
        e_rs1 = (es >= 2) ? 4'd0 : in_rs1;
        e_rs2 = (es != 0) ? 4'd0 : in_rs2;
        na = in_ctrl.rmux_sel[1] ? read_v(e_rs1)
           : (in_ctrl.jmp_sel ? VW'(in_pc) : VW'(read_s(e_rs1)));
        nb = in_ctrl.rmux_sel[0] ? read_v(e_rs2)
           : ((es != 0) ? VW'(ext) : VW'(read_s(e_rs2)));
        use1 = !in_ctrl.jmp_sel && es < 2;
        use2 = (es == 0);
        h1 = use1 && (in_ctrl.rmux_sel[1] == ex_vf) && in_rs1 == ex_rd &&
             !(!in_ctrl.rmux_sel[1] && in_rs1 == 0);
        h2 = use2 && (in_ctrl.rmux_sel[0] == ex_vf) && in_rs2 == ex_rd &&
             !(!in_ctrl.rmux_sel[0] && in_rs2 == 0);
        hz  = m_valid && ex_rmem && in_valid && (h1 || h2);
        rdy = !hz && !flush && (!m_valid || out_ready);
        check_eq("in_ready", VW'(in_ready), VW'(rdy));
        w_en = wb_en; w_vf = wb_vf; w_addr = wb_addr; w_data = wb_data;

        @(posedge clk);
        #1;
        if (w_en) begin
            if (w_vf) m_v[w_addr] = w_data;
            else if (w_addr != 0) m_r[w_addr] = w_data[XLEN-1:0];
        end
        if (flush) begin
            m_valid = 1'b0;
        end else if (in_valid && rdy) begin
            m_valid = 1'b1;
            m_ctrl = in_ctrl;
            m_a = na; m_b = nb;
            m_rd = e_rd; m_rs1 = e_rs1; m_rs2 = e_rs2;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        check_eq("out_valid", VW'(out_valid), VW'(m_valid));
        check_eq("out_ctrl", VW'(out_ctrl), VW'(m_ctrl));
        check_eq("out_a", out_a, m_a);
        check_eq("out_b", out_b, m_b);
        check_eq("out_rd", VW'(out_rd), VW'(m_rd));
        check_eq("out_rs1", VW'(out_rs1), VW'(m_rs1));
        check_eq("out_rs2", VW'(out_rs2), VW'(m_rs2));
    endtask

    task automatic idle();
        in_valid = 0; in_ctrl = '0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
        in_imm = 0; in_pc = 0; flush = 0; ex_rmem = 0; ex_vf = 0; ex_rd = 0;
        wb_en = 0; wb_vf = 0; wb_addr = 0; wb_data = '0; out_ready = 1;
    endtask

    logic [VW-1:0] a_hold;
    logic [VW-1:0] vpat;

    initial begin
        idle();
        m_reset();
        rst_n = 0;
        #3;
        check_eq("rst_valid", VW'(out_valid), '0);
        check_eq("rst_a", out_a, '0);
        check_eq("rst_b", out_b, '0);
        check_eq("rst_ctrl", VW'(out_ctrl), '0);
        check_eq("rst_rd", VW'({out_rd, out_rs1, out_rs2}), '0);
        #10 rst_n = 1;
        @(posedge clk); #1;

        // R3 = 0x1234, then add R1,R3,R3
        wb_en = 1; wb_addr = 3; wb_data = VW'(32'h1234);
        step();
        wb_en = 0;
        in_valid = 1; in_rd = 1; in_rs1 = 3; in_rs2 = 3;
        step();
        check_eq("add_a", out_a, VW'(32'h1234));
        check_eq("add_b", out_b, VW'(32'h1234));

        // vector read of V2 while it is being written
        vpat = 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444;
        in_ctrl.rmux_sel = 2'b10; in_rs1 = 2;
        wb_en = 1; wb_vf = 1; wb_addr = 2; wb_data = vpat;
        step();
        check_eq("vbypass_a", out_a, vpat);
        wb_en = 0; wb_vf = 0;

        // immediates
        in_ctrl = '0; in_ctrl.ext_sel = EXT_SEXT19; in_imm = 27'h0040000;
        step();
        check_eq("sext19_b", out_b, VW'(32'hFFFC0000));
        in_ctrl.ext_sel = EXT_ZEXT_J; in_rd = 7; in_rs1 = 5; in_rs2 = 6; in_imm = 27'h7FF_FFFF;
        step();
        check_eq("ext11_addr", VW'({out_rd, out_rs1, out_rs2}), '0);
        check_eq("zext27_b", out_b, VW'(32'h07FF_FFFF));

        // load-use: load R5, then consumer of R5
        in_ctrl = '0; in_ctrl.rmem = 1; in_rd = 5; in_rs1 = 1; in_rs2 = 2;
        step();
        in_ctrl = '0; ex_rmem = 1; ex_rd = 5; ex_vf = 0; in_rs1 = 5; in_rs2 = 1; in_rd = 4;
        #1 check_eq("haz_ready", VW'(in_ready), '0);
        step();
        check_eq("bubble", VW'(out_valid), '0);
        ex_rmem = 0;
        step();
        check_eq("haz_accept", VW'(out_valid), VW'(1));
        check_eq("haz_rs1", VW'(out_rs1), VW'(5));

        // backpressure with flush in the second stalled cycle
        out_ready = 0; in_rs1 = 1; in_rd = 9;
        a_hold = out_a;
        step();
        check_eq("hold_a", out_a, a_hold);
        flush = 1;
        step();
        check_eq("flush_valid", VW'(out_valid), '0);
        flush = 0; in_valid = 0;
        step();
        check_eq("flush_drop", VW'(out_valid), '0);
        out_ready = 1; in_valid = 1;

        // R0 is hardwired, even while being written
        in_ctrl = '0; in_rs1 = 0; in_rs2 = 0;
        wb_en = 1; wb_vf = 0; wb_addr = 0; wb_data = VW'(32'hFFFF);
        step();
        check_eq("r0_bypass", out_a, '0);
        wb_en = 0;
        step();
        check_eq("r0_read", out_b, '0);

        // async reset pulse while the slot is valid
        in_rs1 = 3;
        step();
        check_eq("pre_rst_valid", VW'(out_valid), VW'(1));
        #2 rst_n = 0;
        #1 check_eq("async_rst", VW'(out_valid), '0);
        m_reset();
        #3 rst_n = 1;
        step();
        check_eq("rf_cleared", out_a, '0);

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ctrl   = ctrl_t'(CW'($urandom));
            in_rd     = AW'($urandom_range(0, 7));
            in_rs1    = AW'($urandom_range(0, 7));
            in_rs2    = AW'($urandom_range(0, 7));
            in_imm    = IMMW'($urandom);
            in_pc     = $urandom;
            flush     = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ex_rmem   = m_ctrl.rmem | ($urandom_range(0, 3) == 0);
            ex_vf     = m_ctrl.vf;
            ex_rd     = m_rd;
            wb_en     = $urandom_range(0, 1) == 1;
            wb_vf     = $urandom_range(0, 1) == 1;
            wb_addr   = AW'($urandom_range(0, 7));
            wb_data   = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
